// File: rtl/signed_div_pow2_pipe.sv
// Two-stage pipelined signed division by 2**sh, truncating toward zero.
// Stage 1 forms the floor shift and bias flags; stage 2 applies the bias and derives the remainder.
module signed_div_pow2_pipe #(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [N-1:0]  up_a,
  input  logic [SW-1:0] up_sh,
  output logic          down_valid,
  input  logic          down_ready,
  output logic [N-1:0]  down_q,
  output logic [N-1:0]  down_r
);

  logic          r_s1_valid;
  logic [N-1:0]  r_s1_fl;
  logic          r_s1_lost;
  logic          r_s1_neg;
  logic [N-1:0]  r_s1_a;
  logic [SW-1:0] r_s1_sh;

  logic          r_s2_valid;
  logic [N-1:0]  r_s2_q;
  logic [N-1:0]  r_s2_r;

  logic          w_s1_ready;
  logic          w_s2_ready;
  logic [N-1:0]  w_fl;
  logic          w_lost;
  logic [N-1:0]  w_q;
  logic [N-1:0]  w_r;

  // A beat moves on a rising edge when valid && ready; a stage may load whenever
  // it is empty or its own contents leave in the same cycle. Ready never depends on valid.
  assign w_s2_ready = !r_s2_valid || down_ready;
  assign w_s1_ready = !r_s1_valid || w_s2_ready;
  assign up_ready   = w_s1_ready;

  // Floor shift: bits shifted in from above the MSB replicate the sign.
  always_comb begin
    w_fl   = '0;
    w_lost = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i + int'(up_sh) < N) w_fl[i] = up_a[i + int'(up_sh)];
      else                     w_fl[i] = up_a[N-1];
      if (i < int'(up_sh))     w_lost  = w_lost | up_a[i];
    end
  end

  always_comb begin
    w_q = r_s1_fl + {{(N-1){1'b0}}, r_s1_neg & r_s1_lost};
    w_r = r_s1_a - (w_q << r_s1_sh);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_fl    <= '0;
      r_s1_lost  <= 1'b0;
      r_s1_neg   <= 1'b0;
      r_s1_a     <= '0;
      r_s1_sh    <= '0;
    end else if (w_s1_ready) begin
      r_s1_valid <= up_valid;
      if (up_valid) begin
        r_s1_fl   <= w_fl;
        r_s1_lost <= w_lost;
        r_s1_neg  <= up_a[N-1];
        r_s1_a    <= up_a;
        r_s1_sh   <= up_sh;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_q     <= '0;
      r_s2_r     <= '0;
    end else if (w_s2_ready) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_q <= w_q;
        r_s2_r <= w_r;
      end
    end
  end

  assign down_valid = r_s2_valid;
  assign down_q     = r_s2_q;
  assign down_r     = r_s2_r;

endmodule

// File: tb/tb_signed_div_pow2_pipe.sv
// Bench for signed_div_pow2_pipe: N=8 and N=6 instances checked against a
// reference built on the language's own signed "/" and "%".
module tb_signed_div_pow2_pipe;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       up_valid8, up_ready8, down_valid8, down_ready8;
  logic [7:0] up_a8, down_q8, down_r8;
  logic [2:0] up_sh8;

  logic       up_valid6, up_ready6, down_valid6, down_ready6;
  logic [5:0] up_a6, down_q6, down_r6;
  logic [2:0] up_sh6;

  int checks = 0;
  int errors = 0;
  int out8_cnt = 0;
  int idx;
  int cnt_before;
  logic [15:0] held;

  // entry = {sh, a, q, r}, 8 bits each, values sign-extended to 8 bits
  logic [31:0] exp_q8[$];
  logic [31:0] exp_q6[$];

  logic [7:0] bp_a [4];
  logic [2:0] bp_sh[4];

  signed_div_pow2_pipe #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .up_valid(up_valid8), .up_ready(up_ready8), .up_a(up_a8), .up_sh(up_sh8),
    .down_valid(down_valid8), .down_ready(down_ready8), .down_q(down_q8), .down_r(down_r8)
  );

  signed_div_pow2_pipe #(.N(6)) dut6 (
    .clk(clk), .rst_n(rst_n),
    .up_valid(up_valid6), .up_ready(up_ready6), .up_a(up_a6), .up_sh(up_sh6),
    .down_valid(down_valid6), .down_ready(down_ready6), .down_q(down_q6), .down_r(down_r6)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers / model ----------------
  function automatic int sx8(input logic [7:0] v);
    return int'(signed'(v));
  endfunction

  function automatic int sx6(input logic [5:0] v);
    return int'(signed'(v));
  endfunction

  function automatic logic [31:0] model(input int a, input int sh);
    int d, q, r;
    d = 1 << sh;
    q = a / d;
    r = a % d;
    return {8'(sh), 8'(a), 8'(q), 8'(r)};
  endfunction

  function automatic int fq(input logic [31:0] e);
    return int'(signed'(e[15:8]));
  endfunction

  function automatic int fr(input logic [31:0] e);
    return int'(signed'(e[7:0]));
  endfunction

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic score(input string tag, input logic [31:0] e, input int aq, input int ar);
    int a, sh, d;
    sh = int'(e[31:24]);
    a  = int'(signed'(e[23:16]));
    d  = 1 << sh;
    check({tag, "_q"}, aq, fq(e));
    check({tag, "_r"}, ar, fr(e));
    check({tag, "_recon"}, aq * d + ar, a);
    check({tag, "_rmag"}, int'(ar < d && ar > -d), 1);
    check({tag, "_rsign"}, int'(ar == 0 || ((ar < 0) == (a < 0))), 1);
  endtask

  // ---------------- scoreboard: monitors and compare ----------------
  always @(negedge clk) begin
    if (rst_n && up_valid8 && up_ready8) exp_q8.push_back(model(sx8(up_a8), int'(up_sh8)));
    if (rst_n && up_valid6 && up_ready6) exp_q6.push_back(model(sx6(up_a6), int'(up_sh6)));
  end

  always @(negedge clk) begin
    if (rst_n && down_valid8 && down_ready8) begin
      out8_cnt++;
      if (exp_q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out8_unexpected: got q=%0d r=%0d, expected no output", sx8(down_q8), sx8(down_r8));
      end else begin
        score("out8", exp_q8.pop_front(), sx8(down_q8), sx8(down_r8));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && down_valid6 && down_ready6) begin
      if (exp_q6.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out6_unexpected: got q=%0d r=%0d, expected no output", sx6(down_q6), sx6(down_r6));
      end else begin
        score("out6", exp_q6.pop_front(), sx6(down_q6), sx6(down_r6));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge with the N=8 pipeline empty and down_ready8=1.
  task automatic fixed_vec(input string name, input int a, input int sh, input int eq, input int er);
    up_a8     = 8'(a);
    up_sh8    = 3'(sh);
    up_valid8 = 1'b1;
    @(negedge clk);
    check({name, "_accept"}, int'(up_ready8), 1);
    @(posedge clk); #1;
    up_valid8 = 1'b0;
    @(negedge clk);
    check({name, "_lat1"}, int'(down_valid8), 0);
    @(negedge clk);
    check({name, "_lat2"}, int'(down_valid8), 1);
    check({name, "_q"}, sx8(down_q8), eq);
    check({name, "_r"}, sx8(down_r8), er);
    @(posedge clk); #1;
  endtask

  task automatic idle8(input int n);
    up_valid8 = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b1;
    up_valid8 = 1'b0; up_a8 = '0; up_sh8 = '0; down_ready8 = 1'b1;
    up_valid6 = 1'b0; up_a6 = '0; up_sh6 = '0; down_ready6 = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_down_valid8", int'(down_valid8), 0);
    check("rst_down_q8", int'(down_q8), 0);
    check("rst_down_r8", int'(down_r8), 0);
    check("rst_down_valid6", int'(down_valid6), 0);
    check("rst_down_q6", int'(down_q6), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_up_ready8", int'(up_ready8), 1);

    // model pins against hand-computed values
    check("model_pos_q", fq(model(7, 1)), 3);
    check("model_pos_r", fr(model(7, 1)), 1);
    check("model_neg_q", fq(model(-7, 1)), -3);
    check("model_neg_r", fr(model(-7, 1)), -1);
    check("model_min_q", fq(model(-128, 7)), -1);
    check("model_max_r", fr(model(127, 7)), 127);

    // fixed vectors and extremes
    fixed_vec("vec_7_1", 7, 1, 3, 1);
    fixed_vec("vec_m7_1", -7, 1, -3, -1);
    fixed_vec("vec_m1_3", -1, 3, 0, -1);
    fixed_vec("ext_m128_0", -128, 0, -128, 0);
    fixed_vec("ext_m128_7", -128, 7, -1, 0);
    fixed_vec("ext_127_7", 127, 7, 0, 127);
    fixed_vec("ext_0_5", 0, 5, 0, 0);

    // streaming: 20 back-to-back transactions
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          up_a8     = 8'($urandom_range(0, 255));
          up_sh8    = 3'($urandom_range(0, 7));
          up_valid8 = 1'b1;
          @(posedge clk); #1;
        end
        up_valid8 = 1'b0;
      end
      begin
        int run, w;
        run = 0;
        w   = 0;
        @(negedge clk);
        while (!down_valid8 && w < 10) begin
          w++;
          @(negedge clk);
        end
        while (down_valid8 && run < 40) begin
          run++;
          @(negedge clk);
        end
        check("stream_run", run, 20);
      end
    join
    @(posedge clk); #1;
    idle8(3);

    // backpressure: 4 transactions, down_ready low for 5 cycles
    bp_a[0] = 8'(-100); bp_sh[0] = 3'd3;
    bp_a[1] = 8'd55;    bp_sh[1] = 3'd2;
    bp_a[2] = 8'(-1);   bp_sh[2] = 3'd0;
    bp_a[3] = 8'd77;    bp_sh[3] = 3'd7;
    idx  = 0;
    held = '0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      down_ready8 = (cyc >= 5);
      if (idx < 4) begin
        up_valid8 = 1'b1;
        up_a8     = bp_a[idx];
        up_sh8    = bp_sh[idx];
      end else begin
        up_valid8 = 1'b0;
      end
      @(negedge clk);
      if (cyc == 4) begin
        check("bp_accepts", idx, 2);
        check("bp_up_ready", int'(up_ready8), 0);
      end
      if (cyc >= 2 && cyc <= 4) begin
        check("bp_valid_hold", int'(down_valid8), 1);
        if (cyc == 2) begin
          held = {down_q8, down_r8};
          check("bp_first_q", sx8(down_q8), -12);
          check("bp_first_r", sx8(down_r8), -4);
        end else begin
          check("bp_stable", int'({down_q8, down_r8}), int'(held));
        end
      end
      if (cyc >= 5 && cyc <= 8) check("bp_release_valid", int'(down_valid8), 1);
      if (cyc == 9) check("bp_drained", int'(down_valid8), 0);
      if (up_valid8 && up_ready8) idx++;
      @(posedge clk); #1;
    end
    check("bp_all_accepted", idx, 4);
    check("bp_queue_empty", exp_q8.size(), 0);

    // reset mid-cycle with 2 transactions in flight
    down_ready8 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      up_a8     = 8'($urandom_range(0, 255));
      up_sh8    = 3'($urandom_range(0, 7));
      up_valid8 = 1'b1;
      @(posedge clk); #1;
    end
    up_valid8 = 1'b0;
    @(negedge clk);
    check("rst_pre_valid", int'(down_valid8), 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    exp_q8.delete();
    exp_q6.delete();
    #1;
    check("rst_async_valid", int'(down_valid8), 0);
    check("rst_async_q", int'(down_q8), 0);
    @(posedge clk); #3;
    rst_n       = 1'b1;
    down_ready8 = 1'b1;
    @(posedge clk); #1;
    cnt_before = out8_cnt;
    for (int i = 0; i < 3; i++) begin
      up_a8     = 8'($urandom_range(0, 255));
      up_sh8    = 3'($urandom_range(0, 7));
      up_valid8 = 1'b1;
      @(posedge clk); #1;
    end
    idle8(5);
    check("rst_post_count", out8_cnt - cnt_before, 3);
    check("rst_post_drain", exp_q8.size(), 0);

    // random soak on both widths
    fork
      begin
        int sent8, cyc8;
        logic acc8;
        sent8 = 0;
        cyc8  = 0;
        up_valid8 = 1'b0;
        while (sent8 < 2000 && cyc8 < 20000) begin
          down_ready8 = ($urandom_range(0, 3) != 0);
          if (!up_valid8 && $urandom_range(0, 9) < 7) begin
            up_valid8 = 1'b1;
            up_a8     = 8'($urandom_range(0, 255));
            up_sh8    = 3'($urandom_range(0, 7));
          end
          @(negedge clk);
          acc8 = up_valid8 && up_ready8;
          @(posedge clk); #1;
          cyc8++;
          if (acc8) begin
            sent8++;
            up_valid8 = 1'b0;
          end
        end
        up_valid8   = 1'b0;
        down_ready8 = 1'b1;
        check("soak8_sent", sent8, 2000);
      end
      begin
        int sent6, cyc6;
        logic acc6;
        sent6 = 0;
        cyc6  = 0;
        up_valid6 = 1'b0;
        while (sent6 < 2000 && cyc6 < 20000) begin
          down_ready6 = ($urandom_range(0, 3) != 0);
          if (!up_valid6 && $urandom_range(0, 9) < 7) begin
            up_valid6 = 1'b1;
            up_a6     = 6'($urandom_range(0, 63));
            up_sh6    = 3'($urandom_range(0, 7));
          end
          @(negedge clk);
          acc6 = up_valid6 && up_ready6;
          @(posedge clk); #1;
          cyc6++;
          if (acc6) begin
            sent6++;
            up_valid6 = 1'b0;
          end
        end
        up_valid6   = 1'b0;
        down_ready6 = 1'b1;
        check("soak6_sent", sent6, 2000);
      end
    join
    repeat (6) @(posedge clk);
    #1;
    check("soak8_drain", exp_q8.size(), 0);
    check("soak6_drain", exp_q6.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
